// File: rtl/instr_mem_responder.sv
// instr_mem_responder
//   Memory-side responder for the instruction-fetch interface. Holds
//   DEPTH_WORDS 32-bit words. It accepts one fetch at a time and returns the
//   word LATENCY cycles after accept over a valid/ready handshake. A load port
//   writes program words while the responder is idle. A flush discards any
//   in-flight or pending response.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   req_valid_i  fetch request valid
//   req_ready_o  fetch request can be accepted this cycle
//   req_addr_i   fetch byte address (PC)
//   flush_i      redirect: kill any in-flight or pending fetch
//   rsp_valid_o  response valid
//   rsp_ready_i  fetch stage consumes the response
//   rsp_instr_o  fetched instruction word (NOP_INSTR on error)
//   rsp_addr_o   byte address the response belongs to
//   rsp_err_o    fetch was misaligned or out of range
//   ld_en_i      write ld_data_i to ld_addr_i this cycle
//   ld_ready_o   load will be accepted this cycle
//   ld_addr_i    load byte address (same mapping/checks as fetch)
//   ld_data_i    word to store
module instr_mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,     // legal range 1..4
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        flush_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_instr_o,
  output logic [31:0] rsp_addr_o,
  output logic        rsp_err_o,
  input  logic        ld_en_i,
  output logic        ld_ready_o,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic addr_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic        req_fire, ld_fire;
  logic        src_err;
  logic [31:0] src_addr;

  // rst_n gating keeps both ready outputs low for the whole reset period.
  assign ld_ready_o  = rst_n && (state_q == IDLE) && !flush_i;
  assign req_ready_o = rst_n && (state_q == IDLE) && !flush_i && !ld_en_i;
  assign req_fire    = req_valid_i && req_ready_o;
  assign ld_fire     = ld_en_i && ld_ready_o;

  // The response is captured either straight from the request (LATENCY=1,
  // entering RESP on the accept edge) or from the latched request in BUSY.
  assign src_addr = (state_q == IDLE) ? req_addr_i : addr_q;
  assign src_err  = (state_q == IDLE) ? addr_err(req_addr_i) : err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    err_d       = err_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          addr_d = req_addr_i;
          err_d  = addr_err(req_addr_i);
          if (LATENCY == 1) begin
            state_d     = RESP;
            rsp_instr_d = src_err ? NOP_INSTR : mem[addr_idx(src_addr)];
            rsp_addr_d  = src_addr;
            rsp_err_d   = src_err;
          end else begin
            state_d = BUSY;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d     = RESP;
            rsp_instr_d = src_err ? NOP_INSTR : mem[addr_idx(src_addr)];
            rsp_addr_d  = src_addr;
            rsp_err_d   = src_err;
          end
        end
      end
      RESP: begin
        // A flush and a handshake both return to IDLE; with flush the
        // response is simply treated as dropped.
        if (flush_i || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= 32'd0;
      err_q       <= 1'b0;
      rsp_instr_q <= 32'd0;
      rsp_addr_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately not reset so program contents survive rst_n.
  // Errored load addresses are dropped.
  always_ff @(posedge clk) begin
    if (ld_fire && !addr_err(ld_addr_i)) mem[addr_idx(ld_addr_i)] <= ld_data_i;
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_instr_o = rsp_instr_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
